ahb_decode_ctrl: RTL and testbench

- AHB-Lite address decoder and data-phase controller for the four-slave interconnect.
- Decodes HADDR into per-slave selects.
- Registers the slave index at each accepted address phase and drives it as the read-data mux select during the following data phase.
- Contains a built-in default slave that returns a two-cycle ERROR response to unmapped accesses, and merges its response into the HREADY/HRESP returned to the master.

---
 rtl/ahb_decode_ctrl.sv | 129 ++++++++++++
 tb/tb_ahb_decode_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decode_ctrl.sv
// AHB-Lite address decoder and data-phase controller for a four-slave interconnect.
// Includes a default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_decode_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [3:0]  S1_REGION = 4'h0,
    parameter logic [3:0]  S2_REGION = 4'h1,
    parameter logic [3:0]  S3_REGION = 4'h2,
    parameter logic [3:0]  S4_REGION = 4'h3
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hready_mux_in,
    output logic              hsel1,
    output logic              hsel2,
    output logic              hsel3,
    output logic              hsel4,
    output logic [1:0]        mux_sel,
    output logic              hready_out,
    output logic              hresp_out,
    output logic              dphase_unmapped,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } dstate_e;

    dstate_e    state_q, state_d;
    logic [1:0] mux_sel_q, mux_sel_d;
    logic       dphase_unmapped_q, dphase_unmapped_d;
    logic [7:0] err_count_q, err_count_d;

    logic [3:0] region;
    logic [1:0] dec_idx;
    logic       mapped;
    logic       accept;

    assign region = haddr[ADDR_W-1 -: 4];

    always_comb begin
        hsel1   = (region == S1_REGION);
        hsel2   = (region == S2_REGION);
        hsel3   = (region == S3_REGION);
        hsel4   = (region == S4_REGION);
        mapped  = hsel1 | hsel2 | hsel3 | hsel4;
        dec_idx = 2'b00;
        if (hsel2) dec_idx = 2'b01;
        if (hsel3) dec_idx = 2'b10;
        if (hsel4) dec_idx = 2'b11;
    end

    // Response outputs depend only on the data-phase owner, never on the new address.
    always_comb begin
        hready_out = hready_mux_in;
        hresp_out  = 1'b0;
        case (state_q)
            D_ERR1: begin
                hready_out = 1'b0;
                hresp_out  = 1'b1;
            end
            D_ERR2: begin
                hready_out = 1'b1;
                hresp_out  = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = hready_out & htrans[1];

    always_comb begin
        state_d           = state_q;
        mux_sel_d         = mux_sel_q;
        dphase_unmapped_d = dphase_unmapped_q;
        err_count_d       = err_count_q;

        case (state_q)
            D_IDLE: begin
                if (accept && !mapped) begin
                    state_d           = D_ERR1;
                    dphase_unmapped_d = 1'b1;
                end else if (accept) begin
                    mux_sel_d = dec_idx;
                end
            end
            D_ERR1: begin
                state_d = D_ERR2;
                if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end
            D_ERR2: begin
                if (accept && !mapped) begin
                    state_d           = D_ERR1;
                    dphase_unmapped_d = 1'b1;
                end else begin
                    state_d           = D_IDLE;
                    dphase_unmapped_d = 1'b0;
                    if (accept) mux_sel_d = dec_idx;
                end
            end
            default: begin
                state_d           = D_IDLE;
                dphase_unmapped_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q           <= D_IDLE;
            mux_sel_q         <= '0;
            dphase_unmapped_q <= 1'b0;
            err_count_q       <= '0;
        end else begin
            state_q           <= state_d;
            mux_sel_q         <= mux_sel_d;
            dphase_unmapped_q <= dphase_unmapped_d;
            err_count_q       <= err_count_d;
        end
    end

    assign mux_sel         = mux_sel_q;
    assign dphase_unmapped = dphase_unmapped_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_ahb_decode_ctrl.sv
// Directed bench for ahb_decode_ctrl: a reference model predicts the combinational
// response and queues the registered state expected after each clock edge.
module tb_ahb_decode_ctrl;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = T_IDLE;
    logic        hready_mux_in = 1'b1;
    logic        hsel1, hsel2, hsel3, hsel4;
    logic [1:0]  mux_sel;
    logic        hready_out, hresp_out, dphase_unmapped;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] mux;
        logic       du;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: 0 = idle, 1 = first error cycle, 2 = second error cycle
    int         m_state = 0;
    logic [1:0] m_mux   = '0;
    logic       m_du    = 1'b0;
    logic [7:0] m_cnt   = '0;
    bit         m_known = 1'b0;

    always #5 hclk = ~hclk;

    ahb_decode_ctrl #(
        .ADDR_W(32),
        .S1_REGION(4'h0),
        .S2_REGION(4'h1),
        .S3_REGION(4'h2),
        .S4_REGION(4'h3)
    ) dut (
        .hclk(hclk),
        .hresetn(hresetn),
        .haddr(haddr),
        .htrans(htrans),
        .hready_mux_in(hready_mux_in),
        .hsel1(hsel1),
        .hsel2(hsel2),
        .hsel3(hsel3),
        .hsel4(hsel4),
        .mux_sel(mux_sel),
        .hready_out(hready_out),
        .hresp_out(hresp_out),
        .dphase_unmapped(dphase_unmapped),
        .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, check decode/response, then check registers after posedge.
    task automatic step(input logic rn, input logic [31:0] a, input logic [1:0] t, input logic rdy);
        logic [3:0] region;
        bit         mapped;
        logic       e_rdy;
        logic       e_resp;
        bit         acc;
        exp_t       e;
        exp_t       got;

        @(negedge hclk);
        hresetn       = rn;
        haddr         = a;
        htrans        = t;
        hready_mux_in = rdy;
        #1;

        region = a[31:28];
        mapped = (region < 4'd4);
        chk("hsel", {28'd0, hsel4, hsel3, hsel2, hsel1},
            mapped ? (32'd1 << region) : 32'd0);

        e_rdy  = (m_state == 0) ? rdy : (m_state == 2);
        e_resp = (m_state != 0);
        if (m_known) begin
            chk("hready_out", {31'd0, hready_out}, {31'd0, e_rdy});
            chk("hresp_out", {31'd0, hresp_out}, {31'd0, e_resp});
        end

        if (!rn) begin
            m_state = 0;
            m_mux   = 2'b00;
            m_du    = 1'b0;
            m_cnt   = 8'h00;
            m_known = 1'b1;
        end else begin
            acc = e_rdy && t[1];
            case (m_state)
                0: begin
                    if (acc && !mapped) begin
                        m_state = 1;
                        m_du    = 1'b1;
                    end else if (acc) begin
                        m_mux = region[1:0];
                    end
                end
                1: begin
                    m_state = 2;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end
                default: begin
                    if (acc && !mapped) begin
                        m_state = 1;
                        m_du    = 1'b1;
                    end else begin
                        m_state = 0;
                        m_du    = 1'b0;
                        if (acc) m_mux = region[1:0];
                    end
                end
            endcase
        end
        e.mux = m_mux;
        e.du  = m_du;
        e.cnt = m_cnt;
        exp_q.push_back(e);

        @(posedge hclk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk("mux_sel", {30'd0, mux_sel}, {30'd0, got.mux});
            chk("dphase_unmapped", {31'd0, dphase_unmapped}, {31'd0, got.du});
            chk("err_count", {24'd0, err_count}, {24'd0, got.cnt});
        end
    endtask

    initial begin
        // Reset with an unmapped NONSEQ pending: it must not be taken
        step(1'b0, 32'h5000_0000, T_NONSEQ, 1'b1);
        step(1'b0, 32'h5000_0000, T_NONSEQ, 1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        chk("reset_err_count", {24'd0, err_count}, 32'd0);

        // Mapped read to slave 3
        step(1'b1, 32'h2000_0010, T_NONSEQ, 1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        chk("mapped_mux_sel", {30'd0, mux_sel}, 32'd2);

        // Wait states from slave 2 hold off the next address
        step(1'b1, 32'h1000_0000, T_NONSEQ, 1'b1);
        step(1'b1, 32'h3000_0000, T_NONSEQ, 1'b0);
        step(1'b1, 32'h3000_0000, T_NONSEQ, 1'b0);
        step(1'b1, 32'h3000_0000, T_NONSEQ, 1'b0);
        chk("wait_mux_sel", {30'd0, mux_sel}, 32'd1);
        step(1'b1, 32'h3000_0000, T_NONSEQ, 1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        chk("after_wait_mux_sel", {30'd0, mux_sel}, 32'd3);

        // Unmapped access, master abandons with IDLE in the second error cycle
        step(1'b1, 32'h8000_0000, T_NONSEQ, 1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b0);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        chk("unmapped_err_count", {24'd0, err_count}, 32'd1);

        // Back-to-back errors, then a mapped NONSEQ out of the second error cycle
        step(1'b1, 32'hA000_0000, T_NONSEQ, 1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        step(1'b1, 32'h9000_0000, T_SEQ,    1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        step(1'b1, 32'h0000_0004, T_NONSEQ, 1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        chk("b2b_err_count", {24'd0, err_count}, 32'd3);
        chk("b2b_mux_sel", {30'd0, mux_sel}, 32'd0);

        // Reset asserted in the middle of an error response
        step(1'b1, 32'hC000_0000, T_NONSEQ, 1'b1);
        step(1'b0, 32'h0000_0000, T_IDLE,   1'b1);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b0);
        step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);

        // Saturation: 256 unmapped transfers from zero
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 32'hF000_0000, T_NONSEQ, 1'b1);
            step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
            step(1'b1, 32'h0000_0000, T_IDLE,   1'b1);
        end
        chk("sat_err_count", {24'd0, err_count}, 32'hFF);

        // Unmapped IDLE and BUSY are zero-wait OKAY
        step(1'b1, 32'hF000_0000, T_IDLE, 1'b1);
        step(1'b1, 32'hF000_0000, T_BUSY, 1'b1);
        chk("idle_unmapped_count", {24'd0, err_count}, 32'hFF);
        chk("idle_unmapped_du", {31'd0, dphase_unmapped}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
